// File: rtl/xup_or_n_event.sv
// Masked N-input OR with edge detection, sticky flags, saturating edge-cycle count
// and four registered output modes (LEVEL, STICKY, PULSE, STRETCH).

module xup_or_n_event_lane (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    input  logic a_bit,
    input  logic mask_bit,
    output logic m,
    output logic rise,
    output logic flag_next,
    output logic flag
);
    logic a_prev;

    assign m         = a_bit & mask_bit;
    assign rise      = a_bit & ~a_prev & mask_bit;
    // Set beats clear when both land on the same edge.
    assign flag_next = (flag & ~clear) | m;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_prev <= 1'b0;
            flag   <= 1'b0;
        end else if (en) begin
            a_prev <= a_bit;
            flag   <= flag_next;
        end
    end
endmodule

module xup_or_n_event #(
    parameter int WIDTH   = 5,
    parameter int STRETCH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] a,
    input  logic             clear,
    output logic             y,
    output logic [WIDTH-1:0] flags,
    output logic [7:0]       count
);
    localparam logic [1:0] MODE_LEVEL   = 2'b00;
    localparam logic [1:0] MODE_STICKY  = 2'b01;
    localparam logic [1:0] MODE_PULSE   = 2'b10;
    localparam logic [1:0] MODE_STRETCH = 2'b11;
    localparam logic [7:0] STRETCH_LD   = 8'(STRETCH);

    logic [WIDTH-1:0] m, rise, flags_next;
    logic             anyrise;
    logic [7:0]       count_base, count_next;
    logic [7:0]       stretch_cnt, stretch_next;
    logic             y_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        xup_or_n_event_lane u_lane (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .clear     (clear),
            .a_bit     (a[i]),
            .mask_bit  (mask[i]),
            .m         (m[i]),
            .rise      (rise[i]),
            .flag_next (flags_next[i]),
            .flag      (flags[i])
        );
    end

    assign anyrise = |rise;

    always_comb begin
        count_base = clear ? 8'd0 : count;
        count_next = count_base;
        if (anyrise && count_base != 8'hff)
            count_next = count_base + 8'd1;
    end

    // Counter only lives in STRETCH mode; a rise reloads it even mid-stretch.
    always_comb begin
        stretch_next = 8'd0;
        if (mode == MODE_STRETCH) begin
            if (anyrise)
                stretch_next = STRETCH_LD;
            else if (stretch_cnt != 8'd0)
                stretch_next = stretch_cnt - 8'd1;
        end
    end

    always_comb begin
        y_next = 1'b0;
        case (mode)
            MODE_LEVEL:   y_next = |m;
            MODE_STICKY:  y_next = |flags_next;
            MODE_PULSE:   y_next = anyrise;
            MODE_STRETCH: y_next = (stretch_next != 8'd0);
            default:      y_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y           <= 1'b0;
            count       <= 8'd0;
            stretch_cnt <= 8'd0;
        end else if (en) begin
            y           <= y_next;
            count       <= count_next;
            stretch_cnt <= stretch_next;
        end
    end
endmodule

// File: tb/tb_xup_or_n_event.sv
// Table-driven bench for xup_or_n_event (WIDTH=5, STRETCH=4) with a scoreboard queue.

module tb_xup_or_n_event;
    logic       clk = 1'b0;
    logic       reset, en, clear;
    logic [1:0] mode;
    logic [4:0] mask, a;
    logic       y;
    logic [4:0] flags;
    logic [7:0] count;

    typedef struct {
        logic       rst, en, clr;
        logic [1:0] mode;
        logic [4:0] mask, a;
        logic       ey;
        logic [4:0] ef;
        logic [7:0] ec;
        string      nm;
    } vec_t;

    typedef struct {
        logic       ey;
        logic [4:0] ef;
        logic [7:0] ec;
        string      nm;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    xup_or_n_event #(.WIDTH(5), .STRETCH(4)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .mask(mask),
        .a(a), .clear(clear), .y(y), .flags(flags), .count(count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic e, logic c, logic [1:0] md, logic [4:0] mk_, logic [4:0] av,
                                logic ey, logic [4:0] ef, logic [7:0] ec, string nm);
        vec_t v;
        v.rst = r; v.en = e; v.clr = c; v.mode = md; v.mask = mk_; v.a = av;
        v.ey = ey; v.ef = ef; v.ec = ec; v.nm = nm;
        return v;
    endfunction

    task automatic run(input vec_t v);
        exp_t x;
        exp_t got;
        reset = v.rst; en = v.en; clear = v.clr; mode = v.mode; mask = v.mask; a = v.a;
        x.ey = v.ey; x.ef = v.ef; x.ec = v.ec; x.nm = v.nm;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        n_cmp++;
        if (y !== got.ey || flags !== got.ef || count !== got.ec) begin
            n_bad++;
            $display("FAIL %s: got y=%b flags=%b count=%0d, want y=%b flags=%b count=%0d",
                     got.nm, y, flags, count, got.ey, got.ef, got.ec);
        end
    endtask

    initial begin
        //              rst en clr mode  mask      a        y  flags     count
        vt.push_back(mk(1, 0, 0, 2'b11, 5'b11111, 5'b11111, 0, 5'b00000, 0, "reset_en0"));
        vt.push_back(mk(0, 1, 0, 2'b00, 5'b11111, 5'b00000, 0, 5'b00000, 0, "lvl_idle"));
        vt.push_back(mk(0, 1, 0, 2'b00, 5'b11111, 5'b00100, 1, 5'b00100, 1, "lvl_a1"));
        vt.push_back(mk(0, 1, 0, 2'b00, 5'b11111, 5'b00100, 1, 5'b00100, 1, "lvl_a2"));
        vt.push_back(mk(0, 1, 0, 2'b00, 5'b11111, 5'b00100, 1, 5'b00100, 1, "lvl_a3"));
        vt.push_back(mk(0, 1, 0, 2'b00, 5'b11111, 5'b00000, 0, 5'b00100, 1, "lvl_drop"));
        vt.push_back(mk(0, 1, 1, 2'b01, 5'b10101, 5'b00000, 0, 5'b00000, 0, "stk_clear"));
        vt.push_back(mk(0, 1, 0, 2'b01, 5'b10101, 5'b00001, 1, 5'b00001, 1, "stk_b0"));
        vt.push_back(mk(0, 1, 0, 2'b01, 5'b10101, 5'b00010, 1, 5'b00001, 1, "stk_b1_masked"));
        vt.push_back(mk(0, 1, 0, 2'b01, 5'b10101, 5'b10000, 1, 5'b10001, 2, "stk_b4"));
        vt.push_back(mk(0, 1, 1, 2'b01, 5'b10101, 5'b00100, 1, 5'b00100, 1, "stk_clear_set"));
        vt.push_back(mk(0, 1, 0, 2'b01, 5'b00000, 5'b00000, 1, 5'b00100, 1, "stk_mask_keep"));
        vt.push_back(mk(0, 1, 1, 2'b10, 5'b11111, 5'b00000, 0, 5'b00000, 0, "pls_clear"));
        vt.push_back(mk(0, 1, 0, 2'b10, 5'b11111, 5'b00011, 1, 5'b00011, 1, "pls_rise"));
        vt.push_back(mk(0, 1, 0, 2'b10, 5'b11111, 5'b00011, 0, 5'b00011, 1, "pls_hold1"));
        vt.push_back(mk(0, 1, 0, 2'b10, 5'b11111, 5'b00011, 0, 5'b00011, 1, "pls_hold2"));
        vt.push_back(mk(0, 1, 0, 2'b10, 5'b11111, 5'b00011, 0, 5'b00011, 1, "pls_hold3"));
        vt.push_back(mk(0, 1, 0, 2'b11, 5'b11111, 5'b00000, 0, 5'b00011, 1, "str_idle"));
        vt.push_back(mk(0, 1, 0, 2'b11, 5'b11111, 5'b00001, 1, 5'b00011, 2, "str_c0"));
        vt.push_back(mk(0, 1, 0, 2'b11, 5'b11111, 5'b00000, 1, 5'b00011, 2, "str_c1"));
        vt.push_back(mk(0, 1, 0, 2'b11, 5'b11111, 5'b00001, 1, 5'b00011, 3, "str_retrig"));
        vt.push_back(mk(0, 1, 0, 2'b11, 5'b11111, 5'b00001, 1, 5'b00011, 3, "str_c3"));
        vt.push_back(mk(0, 1, 0, 2'b11, 5'b11111, 5'b00001, 1, 5'b00011, 3, "str_c4"));
        vt.push_back(mk(0, 1, 0, 2'b11, 5'b11111, 5'b00001, 1, 5'b00011, 3, "str_c5"));
        vt.push_back(mk(0, 1, 0, 2'b11, 5'b11111, 5'b00001, 0, 5'b00011, 3, "str_end"));
        vt.push_back(mk(0, 1, 0, 2'b11, 5'b11111, 5'b00010, 1, 5'b00011, 4, "str_rise2"));
        vt.push_back(mk(0, 1, 0, 2'b00, 5'b11111, 5'b00000, 0, 5'b00011, 4, "str_to_lvl"));
        vt.push_back(mk(0, 1, 0, 2'b11, 5'b11111, 5'b00000, 0, 5'b00011, 4, "str_forced0"));
        vt.push_back(mk(0, 1, 0, 2'b11, 5'b11111, 5'b00100, 1, 5'b00111, 5, "str_rise3"));
        vt.push_back(mk(0, 0, 1, 2'b00, 5'b11111, 5'b11111, 1, 5'b00111, 5, "en0_hold1"));
        vt.push_back(mk(0, 0, 0, 2'b00, 5'b11111, 5'b00000, 1, 5'b00111, 5, "en0_hold2"));
        vt.push_back(mk(0, 1, 0, 2'b11, 5'b11111, 5'b00100, 1, 5'b00111, 5, "en1_aprev_kept"));
        vt.push_back(mk(1, 1, 0, 2'b11, 5'b11111, 5'b11111, 0, 5'b00000, 0, "rst_mid_str"));
        vt.push_back(mk(0, 1, 0, 2'b11, 5'b11111, 5'b11111, 1, 5'b11111, 1, "rst_release"));
        vt.push_back(mk(0, 1, 1, 2'b00, 5'b00000, 5'b00000, 0, 5'b00000, 0, "msk_clear"));
        vt.push_back(mk(0, 1, 0, 2'b00, 5'b00000, 5'b11111, 0, 5'b00000, 0, "msk_toggle_hi"));
        vt.push_back(mk(0, 1, 0, 2'b00, 5'b00000, 5'b00000, 0, 5'b00000, 0, "msk_toggle_lo"));

        reset = 1'b1; en = 1'b0; clear = 1'b0; mode = 2'b00; mask = 5'b0; a = 5'b0;
        @(negedge clk);
        foreach (vt[i]) run(vt[i]);

        // Saturation: 300 single-bit rises in PULSE mode.
        run(mk(0, 1, 1, 2'b10, 5'b00001, 5'b00000, 0, 5'b00000, 0, "sat_clear"));
        for (int k = 1; k <= 300; k++) begin
            run(mk(0, 1, 0, 2'b10, 5'b00001, 5'b00001, 1, 5'b00001, 8'((k > 255) ? 255 : k), "sat_rise"));
            run(mk(0, 1, 0, 2'b10, 5'b00001, 5'b00000, 0, 5'b00001, 8'((k > 255) ? 255 : k), "sat_fall"));
        end

        // Frozen while en=0, whatever the other inputs do.
        for (int k = 0; k < 10; k++)
            run(mk(0, 0, 1'($urandom), 2'($urandom), 5'($urandom), 5'($urandom), 0, 5'b00001, 255, "en0_freeze"));

        run(mk(0, 1, 1, 2'b10, 5'b00001, 5'b00001, 1, 5'b00001, 1, "clear_with_rise"));

        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/xup_or_n_event.md
XUP_OR_N_EVENT -- requirements
Module: xup_or_n_event

Interface
REQ-001 Parameter WIDTH, default 5, number of OR inputs; legal range 2..32.
REQ-002 Parameter STRETCH, default 4, y high-time in STRETCH mode, in clock cycles; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  clock enable; when low, all internal state and outputs SHALL hold.
REQ-006 mode  input  2  output mode: 00 LEVEL, 01 STICKY, 10 PULSE, 11 STRETCH.
REQ-007 mask  input  WIDTH  per-bit enable; only bits with mask=1 take part in any function.
REQ-008 a  input  WIDTH  OR inputs; synchronous to clk.
REQ-009 clear  input  1  clears flags and count.
REQ-010 y  output  1  registered OR result per mode.
REQ-011 flags  output  WIDTH  sticky record of masked input bits seen high.
REQ-012 count  output  8  saturating count of cycles with at least one masked rising edge.

Function
REQ-013 Definitions, evaluated in each cycle with en=1: m = a & mask; rise = a & ~a_prev & mask; anyrise = |rise.
REQ-014 a_prev SHALL load a on every en=1 edge.
REQ-015 LEVEL (00): y SHALL equal |m from the previous edge (1-cycle latency).
REQ-016 STICKY (01): y SHALL equal |flags_next, so y rises on the same edge as the first captured bit.
REQ-017 PULSE (10): y SHALL be 1 for exactly one cycle on each edge where anyrise=1, otherwise 0.
REQ-018 STRETCH (11): anyrise SHALL load a down-counter with STRETCH; y SHALL be 1 while the counter is nonzero; the counter decrements by 1 per en=1 cycle.
REQ-019 STRETCH retrigger: anyrise while the counter is nonzero SHALL reload STRETCH, giving no gap in y.
REQ-020 The stretch counter SHALL be forced to 0 on any cycle where mode != 11.
REQ-021 Mode change SHALL take effect on the first edge at which the new mode is sampled, with no extra latency.
REQ-022 flags_next = (clear ? 0 : flags) | m; flags SHALL update in all modes.
REQ-023 Simultaneous clear and a set bit: set wins; that bit SHALL be 1 after the edge.
REQ-024 count_next = (clear ? 0 : count) + anyrise, saturating at 255; count updates in all modes.
REQ-025 A count of 255 SHALL hold at 255 on a further anyrise; clear with anyrise SHALL give 1.
REQ-026 Multiple bits rising in one cycle SHALL increment count by 1 only.
REQ-027 Masked-off bits SHALL NOT affect y, flags or count, even when they toggle.
REQ-028 Mask changes SHALL NOT clear existing flags bits.
REQ-029 en=0 SHALL freeze a_prev, flags, count, y and the stretch counter.
REQ-030 On return to en=1, edges SHALL be detected relative to the last a_prev value sampled.
REQ-031 en=0 SHALL NOT override reset.

Reset
REQ-032 With reset=1 at an edge, y=0, flags=0, count=0, a_prev=0 and stretch counter=0 SHALL result, regardless of en, clear or mode.
REQ-033 Reset SHALL take priority over all other inputs.
REQ-034 Reset mid-stretch SHALL drop y to 0 on the reset edge.
REQ-035 Input bits already high when reset is released SHALL register as rising edges on the first edge after release.

Verification
REQ-036 LEVEL, WIDTH=5, mask=11111, a=00100 for 3 cycles then 00000 -> y=1 for 3 cycles, starting 1 cycle after a, then 0; count=1.
REQ-037 STICKY, mask=10101, a pulses 00001 then 00010 then 10000 -> flags=10001, y stays 1; clear with a=00100 in the same cycle -> flags=00100.
REQ-038 PULSE, a rises 00000->00011 and is held 4 cycles -> y=1 for exactly 1 cycle; count increments by 1.
REQ-039 STRETCH=4, rise at cycle 0 and rise at cycle 2 -> y high from cycle 1 through cycle 6, continuous; mode switched to 00 mid-stretch -> y follows LEVEL next edge.
REQ-040 Drive 300 rising edges -> count=255; en=0 for 10 cycles while a toggles -> all outputs unchanged.
REQ-041 Reset asserted mid-stretch with a=11111 -> outputs 0; after release, first edge gives count=1.
